fxp_seq_mult_sm: RTL
====================

Name: fxp_seq_mult_sm

Overview:
Parametrised sequential fixed-point multiplier for sign-magnitude operands, successor to the single-bit shift-add multiplier used in the actuator control loop. It processes K multiplier bits per clock and latches both operands at start, so results no longer depend on inputs held stable. It adds round-half-up, saturation with an overflow flag, and a start/busy/valid handshake. It serves the controller datapath (gain × error products) wherever area matters more than latency.

Parameters:
WIDTH, 16, total word width: bit WIDTH-1 is sign, bits WIDTH-2:0 are magnitude (M = WIDTH-1 bits)
FBITS, 10, fractional bits of the magnitude; legal range 1..M-1
K, 1, multiplier bits consumed per CALC cycle; legal range 1..M; C = ceil(M/K) CALC cycles
ROUND, 0, 0 = truncate, 1 = round half up (add 2^(FBITS-1) before the shift)
SATURATE, 1, 1 = clamp on overflow, 0 = wrap (keep the low M bits)

Ports:
clk_i  in  1  clock; all logic on the rising edge
reset_i  in  1  synchronous reset, active-high
start_i  in  1  request; accepted only when busy_o=0
in1_i  in  WIDTH  multiplicand, sign-magnitude
in2_i  in  WIDTH  multiplier, sign-magnitude
out_o  out  WIDTH  registered result, sign-magnitude; held until the next valid_o
valid_o  out  1  one-cycle pulse: out_o/overflow_o updated
overflow_o  out  1  set with valid_o if the magnitude exceeded 2^M-1; held with out_o
busy_o  out  1  high in CALC and DONE

Behaviour:
- Reset (reset_i=1 at an edge): state IDLE; out_o=0, valid_o=0, overflow_o=0, busy_o=0; accumulator, counter and operand registers cleared. Reset overrides every other input. Reset mid-operation aborts: no valid_o is produced and out_o returns to 0.
- States: IDLE, CALC, DONE.
- IDLE: at an edge with start_i=1, latch magnitudes A=in1_i[M-1:0] and B=in2_i[M-1:0] and sign S=in1_i[WIDTH-1]^in2_i[WIDTH-1]; clear the 2M-bit accumulator; cnt=0; go to CALC. start_i=0: stay in IDLE.
- CALC: each edge adds A × B[cnt*K +: K] << (cnt*K) to the accumulator. Bits of B above M-1 read as 0. cnt increments; after the C-th CALC edge go to DONE.
- DONE: one edge computes P = (acc + (ROUND ? 2^(FBITS-1) : 0)) >> FBITS, at width 2M+1.
  - If P > 2^M-1: overflow_o=1; magnitude = SATURATE ? 2^M-1 : P[M-1:0]. Otherwise overflow_o=0 and magnitude = P[M-1:0].
  - Sign bit = S, except that a zero magnitude forces sign 0.
  - Register out_o; assert valid_o for exactly the next cycle; go to IDLE.
- Latency: start sampled at edge 0; valid_o is high after edge C+1, i.e. C+1 cycles (16 for the defaults).
- start_i while busy_o=1 is ignored, with no queueing, and operand changes have no effect. In the cycle valid_o=1 the state is already IDLE, so a new start is accepted there (back-to-back throughput C+1 cycles).
- Zero operands still take the full C cycles; there is no early exit.
- No combinational path from inputs to outputs.

Test Plan:
- Defaults; in1=0x0600 (1.5), in2=0x0800 (2.0), start at edge 0 -> valid_o pulses after edge 16, out_o=0x0C00, overflow_o=0, busy_o high for edges 1..16 only.
- in1=0x8600 (-1.5), in2=0x0800 -> out_o=0x8C00. Then in1=0x8001, in2=0x0001 -> out_o=0x0000 (sign forced 0).
- in1=0x0001, in2=0x0200 (0.5 LSB product): ROUND=0 -> out_o=0x0000; ROUND=1 -> out_o=0x0001.
- in1=0x7C00 (31.0), in2=0x0800: SATURATE=1 -> out_o=0x7FFF, overflow_o=1; SATURATE=0 -> out_o=0x7800, overflow_o=1; next non-overflow result clears overflow_o.
- K=5 (C=3), 0x0600 × 0x0800 -> valid after edge 4, out_o=0x0C00. Second start asserted in the valid_o cycle -> accepted, next valid 4 cycles later. start during CALC -> ignored.
- reset_i=1 at CALC edge 5 -> no valid_o, out_o=0, busy_o=0; start at the next edge -> normal result with 16-cycle latency.

Source files
------------

// File: rtl/fxp_seq_mult_sm.sv
// Sequential sign-magnitude fixed-point multiplier.
// Consumes K multiplier bits per cycle, then rounds, saturates and signs the result.
//
// state | meaning
// IDLE  | waiting for start_i; valid_o pulses here for one cycle after DONE
// CALC  | one partial product of K multiplier bits accumulated per cycle
// DONE  | round, shift, clamp/wrap and register the result
module fxp_seq_mult_sm #(
  parameter int WIDTH    = 16,
  parameter int FBITS    = 10,
  parameter int K        = 1,
  parameter int ROUND    = 0,
  parameter int SATURATE = 1
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic             start_i,
  input  logic [WIDTH-1:0] in1_i,
  input  logic [WIDTH-1:0] in2_i,
  output logic [WIDTH-1:0] out_o,
  output logic             valid_o,
  output logic             overflow_o,
  output logic             busy_o
);

  localparam int M  = WIDTH - 1;
  localparam int C  = (M + K - 1) / K;
  localparam int CW = $clog2(C + 1);
  localparam logic [2*M:0] RND_ADD =
    (ROUND != 0) ? ((2*M+1)'(1) << (FBITS - 1)) : '0;

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t         state;
  logic [2*M-1:0] a_sh;
  logic [M-1:0]   b_q;
  logic           s_q;
  logic [2*M-1:0] acc;
  logic [CW-1:0]  cnt;

  logic [2*M-1:0] digit_ext;
  logic [2*M-1:0] partial;
  logic [2*M:0]   p_full;
  logic           ovf;
  logic [M-1:0]   mag;
  logic           sign;

  // Partial product of the shifted multiplicand and the current multiplier digit.
  always_comb begin
    digit_ext = {{(2*M-K){1'b0}}, b_q[K-1:0]};
    partial   = a_sh * digit_ext;
  end

  // Final rounding, scaling and overflow handling of the accumulated product.
  always_comb begin
    p_full = ({1'b0, acc} + RND_ADD) >> FBITS;
    ovf    = |p_full[2*M:M];
    mag    = p_full[M-1:0];
    if (ovf && (SATURATE != 0)) mag = '1;
    sign   = s_q & (|mag);
  end

  // Control FSM with registered datapath and outputs; cnt counts down to terminal zero.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state      <= IDLE;
      a_sh       <= '0;
      b_q        <= '0;
      s_q        <= 1'b0;
      acc        <= '0;
      cnt        <= '0;
      out_o      <= '0;
      valid_o    <= 1'b0;
      overflow_o <= 1'b0;
      busy_o     <= 1'b0;
    end else begin
      valid_o <= 1'b0;
      case (state)
        IDLE: begin
          if (start_i) begin
            a_sh   <= {{M{1'b0}}, in1_i[M-1:0]};
            b_q    <= in2_i[M-1:0];
            s_q    <= in1_i[WIDTH-1] ^ in2_i[WIDTH-1];
            acc    <= '0;
            cnt    <= CW'(C - 1);
            busy_o <= 1'b1;
            state  <= CALC;
          end
        end
        CALC: begin
          acc  <= acc + partial;
          a_sh <= a_sh << K;
          b_q  <= b_q >> K;
          if (cnt == '0) state <= DONE;
          else           cnt   <= cnt - 1'b1;
        end
        DONE: begin
          out_o      <= {sign, mag};
          overflow_o <= ovf;
          valid_o    <= 1'b1;
          busy_o     <= 1'b0;
          state      <= IDLE;
        end
        default: begin
          busy_o <= 1'b0;
          state  <= IDLE;
        end
      endcase
    end
  end

endmodule
